// File: rtl/bram_pattern_loader.sv
// Packs a valid/ready byte stream little-endian into 16-bit words and writes them to BRAM port A.
// Optional running checksum of each frame's bytes is enabled with LOADER_CHECKSUM_EN.
module bram_pattern_loader #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        frame_sync,
  output logic [15:0] bram_addra,
  output logic [15:0] bram_dina,
  output logic        bram_ena,
  output logic        bram_wea,
  output logic        frame_done,
  output logic        busy
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  // state | meaning
  // S_LO  | waiting for the low byte of a word
  // S_HI  | low byte held, waiting for the high byte
  // S_WR  | write strobe on port A, stream paused for one cycle
  typedef enum logic [1:0] {S_LO, S_HI, S_WR} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [7:0]              lo_byte;
  logic                    xfer;
  logic                    wr_go;
  logic                    last_word;

  // in_ready is gated by rst so every output reads 0 while reset is held.
  assign in_ready  = (state == S_LO || state == S_HI) && !frame_sync && !rst;
  assign xfer      = in_valid && in_ready;
  assign wr_go     = (state == S_HI) && xfer;
  assign last_word = (word_addr == {ADDR_WIDTH{1'b1}});
  assign busy      = (state != S_LO);

  always_comb begin
    state_nxt = state;
    case (state)
      S_LO:    if (xfer) state_nxt = S_HI;
      S_HI:    if (xfer) state_nxt = S_WR;
      S_WR:    state_nxt = S_LO;
      default: state_nxt = S_LO;
    endcase
    if (frame_sync) state_nxt = S_LO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_LO;
      word_addr  <= '0;
      lo_byte    <= '0;
      bram_addra <= '0;
      bram_dina  <= '0;
      bram_ena   <= 1'b0;
      bram_wea   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nxt;

      if (frame_sync)
        lo_byte <= '0;
      else if (state == S_LO && xfer)
        lo_byte <= in_data;

      // Strobe is registered so it is visible exactly during the S_WR cycle.
      bram_ena   <= wr_go;
      bram_wea   <= wr_go;
      bram_addra <= wr_go ? 16'(word_addr) : 16'h0000;
      bram_dina  <= wr_go ? {in_data, lo_byte} : 16'h0000;
      frame_done <= wr_go && last_word;

      if (frame_sync)
        word_addr <= '0;
      else if (state == S_WR)
        word_addr <= word_addr + ADDR_WIDTH'(1);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] run_sum;

  // Checksum is captured on the hi-byte edge so it is already valid while frame_done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_sum  <= '0;
      checksum <= '0;
    end else if (frame_sync) begin
      run_sum <= '0;
    end else if (wr_go && last_word) begin
      checksum <= run_sum + in_data;
      run_sum  <= '0;
    end else if (xfer) begin
      run_sum <= run_sum + in_data;
    end
  end
`endif

endmodule

// File: tb/tb_bram_pattern_loader.sv
// Self-checking bench for bram_pattern_loader: directed vector table plus multi-cycle sequences.
// Define LOADER_CHECKSUM_EN for both bench and RTL to cover the checksum output.
`timescale 1ns/1ps
module tb_bram_pattern_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        frame_sync = 1'b0;
  logic [15:0] bram_addra;
  logic [15:0] bram_dina;
  logic        bram_ena;
  logic        bram_wea;
  logic        frame_done;
  logic        busy;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int checks = 0;
  int errors = 0;

  bram_pattern_loader #(.ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .frame_sync (frame_sync),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_ena   (bram_ena),
    .bram_wea   (bram_wea),
    .frame_done (frame_done),
    .busy       (busy)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        sync;
    logic        rdy;
    logic        ena;
    logic [15:0] addr;
    logic [15:0] dina;
    logic        done;
    logic        busy;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    frame_sync = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Starts 1ns after an edge in S_LO; leaves the bench 1ns after the edge ending S_WR.
  task automatic send_word(input logic [7:0] lo, input logic [7:0] hi, input bit sync_wr,
                           output logic [15:0] a, output logic [15:0] d, output logic en);
    in_valid = 1'b1;
    in_data = lo;
    @(posedge clk); #1;
    in_data = hi;
    @(posedge clk); #1;
    a = bram_addra;
    d = bram_dina;
    en = bram_ena;
    in_valid = 1'b0;
    frame_sync = sync_wr;
    @(posedge clk); #1;
    frame_sync = 1'b0;
  endtask

  logic [7:0]  stream[64];
  logic [15:0] a_obs, d_obs;
  logic        en_obs;

  initial begin
    //          data  v  s  rdy ena addr     dina     done busy
    vecs[0]  = '{8'h34, 1, 0, 1, 0, 16'h0000, 16'h0000, 0, 1};
    vecs[1]  = '{8'h12, 1, 0, 1, 1, 16'h0000, 16'h1234, 0, 1};
    vecs[2]  = '{8'h00, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0};
    vecs[3]  = '{8'hAA, 1, 0, 1, 0, 16'h0000, 16'h0000, 0, 1};
    vecs[4]  = '{8'h00, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0};
    vecs[5]  = '{8'h01, 1, 0, 1, 0, 16'h0000, 16'h0000, 0, 1};
    vecs[6]  = '{8'h00, 1, 0, 1, 1, 16'h0000, 16'h0001, 0, 1};
    vecs[7]  = '{8'h77, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0};
    vecs[8]  = '{8'h77, 1, 0, 1, 0, 16'h0000, 16'h0000, 0, 1};
    vecs[9]  = '{8'h88, 1, 0, 1, 1, 16'h0001, 16'h8877, 0, 1};
    vecs[10] = '{8'h00, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0};
    vecs[11] = '{8'h01, 1, 0, 1, 0, 16'h0000, 16'h0000, 0, 1};
    vecs[12] = '{8'h02, 1, 0, 1, 1, 16'h0000, 16'h0201, 0, 1};
    vecs[13] = '{8'h99, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0};
    vecs[14] = '{8'h99, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0};
    vecs[15] = '{8'h03, 1, 0, 1, 0, 16'h0000, 16'h0000, 0, 1};
    vecs[16] = '{8'h04, 1, 0, 1, 1, 16'h0000, 16'h0403, 0, 1};
    vecs[17] = '{8'h00, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0};

    for (int i = 0; i < 64; i++) stream[i] = (i < 32) ? 8'(i + 1) : 8'h00;

    // Reset state
    do_reset();
    #1;
    chk("rst_ena", {31'd0, bram_ena}, 32'd0);
    chk("rst_wea", {31'd0, bram_wea}, 32'd0);
    chk("rst_addr", {16'd0, bram_addra}, 32'd0);
    chk("rst_dina", {16'd0, bram_dina}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
    chk("rst_checksum", {24'd0, checksum}, 32'd0);
`endif

    // Vector table
    for (int i = 0; i < 18; i++) begin
      in_data = vecs[i].data;
      in_valid = vecs[i].valid;
      frame_sync = vecs[i].sync;
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].rdy});
      @(posedge clk); #1;
      chk($sformatf("v%0d_ena", i), {31'd0, bram_ena}, {31'd0, vecs[i].ena});
      chk($sformatf("v%0d_wea", i), {31'd0, bram_wea}, {31'd0, vecs[i].ena});
      chk($sformatf("v%0d_addr", i), {16'd0, bram_addra}, {16'd0, vecs[i].addr});
      chk($sformatf("v%0d_dina", i), {16'd0, bram_dina}, {16'd0, vecs[i].dina});
      chk($sformatf("v%0d_done", i), {31'd0, frame_done}, {31'd0, vecs[i].done});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
    end
    in_valid = 1'b0;
    frame_sync = 1'b0;

    // Streaming at full rate: two frames, 32 words, 3 clocks apart
    begin
      int sent = 0;
      int nwr = 0;
      int last_cyc = -1;
      bit prev_done = 0;
      bit hs;
      do_reset();
      for (int cyc = 0; cyc < 400 && nwr < 32; cyc++) begin
        in_valid = (sent < 64);
        in_data = (sent < 64) ? stream[sent] : 8'h00;
        #2;
        hs = in_valid && in_ready;
        @(posedge clk);
        if (hs) sent++;
        #1;
`ifdef LOADER_CHECKSUM_EN
        if (prev_done)
          chk($sformatf("checksum_frame%0d", nwr / 16), {24'd0, checksum},
              (nwr <= 16) ? 32'h10 : 32'h00);
`endif
        prev_done = frame_done;
        if (bram_ena) begin
          chk($sformatf("s%0d_wea", nwr), {31'd0, bram_wea}, 32'd1);
          chk($sformatf("s%0d_addr", nwr), {16'd0, bram_addra}, 32'(nwr % 16));
          chk($sformatf("s%0d_dina", nwr), {16'd0, bram_dina},
              {16'd0, stream[2*nwr+1], stream[2*nwr]});
          chk($sformatf("s%0d_done", nwr), {31'd0, frame_done}, (nwr % 16 == 15) ? 32'd1 : 32'd0);
          chk($sformatf("s%0d_ready_in_wr", nwr), {31'd0, in_ready}, 32'd0);
          if (last_cyc >= 0) chk($sformatf("s%0d_spacing", nwr), 32'(cyc - last_cyc), 32'd3);
          last_cyc = cyc;
          nwr++;
        end else if (frame_done) begin
          chk("stray_frame_done", 32'd1, 32'd0);
        end
      end
      in_valid = 1'b0;
      chk("stream_write_count", 32'(nwr), 32'd32);
      chk("stream_bytes_consumed", 32'(sent), 32'd64);
      @(posedge clk); #1;
`ifdef LOADER_CHECKSUM_EN
      if (prev_done) chk("checksum_frame1_final", {24'd0, checksum}, 32'h00);
`endif
    end

    // frame_sync during the write at address 5
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_word(8'(k), 8'h00, 1'b0, a_obs, d_obs, en_obs);
      chk($sformatf("pre_w%0d_addr", k), {16'd0, a_obs}, 32'(k));
    end
    send_word(8'h05, 8'h50, 1'b1, a_obs, d_obs, en_obs);
    chk("sync_wr_ena", {31'd0, en_obs}, 32'd1);
    chk("sync_wr_addr", {16'd0, a_obs}, 32'd5);
    chk("sync_wr_dina", {16'd0, d_obs}, 32'h5005);
    send_word(8'h06, 8'h60, 1'b0, a_obs, d_obs, en_obs);
    chk("after_sync_addr", {16'd0, a_obs}, 32'd0);
    chk("after_sync_dina", {16'd0, d_obs}, 32'h6006);

    // rst after a lo byte, and rst while the strobe is visible
    send_word(8'h10, 8'h20, 1'b0, a_obs, d_obs, en_obs);
    in_valid = 1'b1;
    in_data = 8'h11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send_word(8'h22, 8'h33, 1'b0, a_obs, d_obs, en_obs);
    chk("post_rst_addr", {16'd0, a_obs}, 32'd0);
    chk("post_rst_dina", {16'd0, d_obs}, 32'h3322);

    in_valid = 1'b1;
    in_data = 8'h44;
    @(posedge clk); #1;
    in_data = 8'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("strobe_before_rst", {31'd0, bram_ena}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("strobe_rst_ena", {31'd0, bram_ena}, 32'd0);
    chk("strobe_rst_wea", {31'd0, bram_wea}, 32'd0);
    chk("strobe_rst_addr", {16'd0, bram_addra}, 32'd0);
    chk("strobe_rst_dina", {16'd0, bram_dina}, 32'd0);
    #1 rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
